nap_stream_tx_arbiter: RTL and testbench
========================================

Name: nap_stream_tx_arbiter

Overview:
- Parametrised N-channel packet arbiter feeding a single NAP data-stream transmit port (towards the NoC).
- Round-robin arbitration is packet-atomic: a grant is held from the SOP beat to the EOP beat.
- NoC destination is taken per channel at SOP and held for the whole packet.
- Registered output through a 2-entry skid buffer, so the NAP-side ready never reaches the input ready combinationally.

Parameters:
- NUM_CH, 4, number of user channels; legal range 2..8.
- DATA_WIDTH, 293, beat data width; matches the horizontal NAP stream.
- ADDR_WIDTH, 4, NoC destination address width.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  NUM_CH  per-channel beat valid.
- o_ready  out  NUM_CH  per-channel beat accept.
- i_sop  in  NUM_CH  per-channel start of packet.
- i_eop  in  NUM_CH  per-channel end of packet.
- i_data  in  NUM_CH*DATA_WIDTH  per-channel beat data; channel c occupies slice [c*DATA_WIDTH +: DATA_WIDTH].
- i_dest  in  NUM_CH*ADDR_WIDTH  per-channel NoC destination; sampled only on an accepted SOP beat.
- o_valid  out  1  NAP-side valid.
- i_ready  in  1  NAP-side ready.
- o_sop  out  1  NAP-side start of packet.
- o_eop  out  1  NAP-side end of packet.
- o_data  out  DATA_WIDTH  NAP-side data.
- o_dest  out  ADDR_WIDTH  NAP-side destination.
- o_busy  out  1  a packet is in progress (LOCKED state).
- o_cur_ch  out  3  currently granted channel; last grant when IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, rr pointer = 0, o_cur_ch = 0.
  - Skid buffer empty: o_valid = 0, o_sop/o_eop/o_data/o_dest = 0.
  - o_ready = 0, o_busy = 0.
- Handshake: a beat transfers when valid && ready, on both sides. o_valid is held with stable payload until i_ready.
- State IDLE:
  - Eligible channels: i_valid[c] && i_sop[c].
  - Pick the first eligible channel at or after rr pointer, wrapping modulo NUM_CH.
  - Grant is combinational: o_ready[g] = skid-has-space in the same cycle.
  - On accept: latch i_dest[g] into dest_q; if i_eop[g] = 0, go to LOCKED; if i_eop[g] = 1 (single-beat packet), stay IDLE and set rr = g+1 mod NUM_CH.
- State LOCKED (grant g):
  - o_ready[g] = skid-has-space; all other o_ready = 0.
  - Every beat is forwarded with o_dest = dest_q, not the live i_dest.
  - On accepted EOP: go to IDLE, rr = g+1 mod NUM_CH.
  - An SOP seen mid-packet is forwarded unchanged; it is not an error.
- Non-SOP beats on ungranted channels while IDLE are stalled (o_ready = 0), never dropped.
- Latency: accepted input beat appears on o_valid the next cycle when the buffer is empty. Throughput is 1 beat/cycle while i_ready = 1.
- Skid buffer:
  - 2 entries; "space" = fewer than 2 entries, registered from the occupancy count.
  - Simultaneous push and pop at count 2 is not possible (space = 0). At count 1 the count is unchanged.
  - At most one beat is accepted per cycle across all channels.
- Reset asserted mid-packet: buffered beats are discarded, lock released, rr = 0. No partial-packet recovery.
- o_cur_ch width is fixed at 3; upper bits are 0 when NUM_CH < 8.

Decomposition:
- Package nap_stream_pkg:
  - t_nap_beat struct {sop, eop, dest[ADDR_WIDTH], data[DATA_WIDTH]} with the widths as package localparams matching the defaults.
  - t_arb_state enum {IDLE, LOCKED}.
  - Round-robin pick function returning the first eligible index from the pointer.
- Sub-module nap_stream_skid: 2-entry registered skid buffer on t_nap_beat, same i_clk/i_reset_n. It is reusable on the receive side later.

Test Plan:
- Single channel 0 sends a 3-beat packet, dest=4'h5, i_ready=1 -> o_sop on beat 1, o_eop on beat 3, o_dest=5 on all beats, first o_valid 1 cycle after accept.
- Channels 0..3 each present a 2-beat packet simultaneously, rr=0 -> output order ch0,ch1,ch2,ch3, no interleaving, o_busy high during each packet.
- Channel 1 mid-packet while channel 2 raises SOP -> channel 2 o_ready = 0 until ch1 EOP accepted, then granted next cycle. Change i_dest[1] mid-packet -> o_dest unchanged.
- i_ready toggled 1,0,0,1 during a 4-beat stream -> no beat lost or duplicated; o_data stable while o_valid && !i_ready; o_ready deasserts when buffer holds 2.
- Single-beat packets (sop=eop=1) on ch3 and ch0 back-to-back -> alternate grants, rr advances 3->0->1, no LOCKED entry.
- Assert i_reset_n=0 on beat 2 of a 4-beat packet -> o_valid = 0 and o_busy = 0 immediately; after release a new ch2 packet is granted first (rr=0, only eligible).

Source files
------------

// File: rtl/nap_stream_pkg.sv
// -----------------------------------------------------------------------------
// nap_stream_pkg
// Shared types and helpers for the NAP data-stream transmit arbiter and its
// skid buffer.
//   t_nap_beat  : one stream beat {sop, eop, dest, data}
//   t_arb_state : arbiter FSM states
//   rr_pick     : round-robin selection starting at a pointer, with wrap
//   rr_next     : pointer advance modulo the channel count
// -----------------------------------------------------------------------------
package nap_stream_pkg;

    localparam int NAP_DATA_WIDTH = 293;
    localparam int NAP_ADDR_WIDTH = 4;
    localparam int NAP_MAX_CH     = 8;

    typedef struct packed {
        logic                      sop;
        logic                      eop;
        logic [NAP_ADDR_WIDTH-1:0] dest;
        logic [NAP_DATA_WIDTH-1:0] data;
    } t_nap_beat;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } t_arb_state;

    // First set bit of elig at or after ptr, wrapping modulo num_ch.
    // Returns 0 when nothing is eligible; callers qualify with |elig.
    function automatic logic [2:0] rr_pick(input logic [NAP_MAX_CH-1:0] elig,
                                           input logic [2:0]            ptr,
                                           input int unsigned           num_ch);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int unsigned i = 0; i < NAP_MAX_CH; i++) begin
            idx = (32'(ptr) + i) % num_ch;
            if (!found && (i < num_ch) && elig[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [2:0] rr_next(input logic [2:0]  ch,
                                           input int unsigned num_ch);
        return ((32'(ch) + 1) >= num_ch) ? 3'd0 : ch + 3'd1;
    endfunction

endpackage

// File: rtl/nap_stream_skid.sv
// -----------------------------------------------------------------------------
// nap_stream_skid
// Two-entry registered skid buffer carrying t_nap_beat. The upstream ready
// comes from a flop derived from the occupancy count, so the downstream ready
// never reaches the upstream ready combinationally.
//
// Valid/ready: a beat moves across an interface on every clock edge where
// valid && ready. A producer holds valid and payload stable until accepted.
// o_ready only depends on registered state, so the producer may use it to
// form i_valid in the same cycle.
//
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_valid, o_ready : upstream handshake (o_ready = fewer than 2 entries)
//   i_beat           : upstream beat
//   o_valid, i_ready : downstream handshake
//   o_beat           : downstream beat, driven straight from the head register
// -----------------------------------------------------------------------------
module nap_stream_skid
    import nap_stream_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_reset_n,
    input  logic      i_valid,
    output logic      o_ready,
    input  t_nap_beat i_beat,
    output logic      o_valid,
    input  logic      i_ready,
    output t_nap_beat o_beat
);

    t_nap_beat  head_q;
    t_nap_beat  tail_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       space_q;
    logic       push;
    logic       pop;

    assign o_valid = (count_q != 2'd0);
    assign o_ready = space_q;
    assign o_beat  = head_q;
    assign push    = i_valid && space_q;
    assign pop     = o_valid && i_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= 2'd0;
            space_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            space_q <= (count_d != 2'd2);
            case (count_q)
                2'd0: begin
                    if (push) head_q <= i_beat;
                end
                2'd1: begin
                    if (push && pop) head_q <= i_beat;
                    else if (push)   tail_q <= i_beat;
                end
                2'd2: begin
                    // Full: no push is possible, a pop promotes the tail.
                    if (pop) head_q <= tail_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nap_stream_tx_arbiter.sv
// -----------------------------------------------------------------------------
// nap_stream_tx_arbiter
// Packet-atomic round-robin arbiter merging NUM_CH user streams onto one NAP
// data-stream transmit port. A grant is taken on an SOP beat and held until
// the EOP beat of the same channel is accepted. The NoC destination is
// captured with the SOP beat and reused for every beat of the packet.
//
// Ports:
//   i_clk, i_reset_n        : clock, asynchronous active-low reset
//   i_valid/o_ready         : per-channel handshake (one bit per channel)
//   i_sop/i_eop             : per-channel packet delimiters
//   i_data                  : channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   i_dest                  : channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   o_valid/i_ready         : NAP-side handshake
//   o_sop/o_eop/o_data/o_dest : NAP-side beat (registered)
//   o_busy                  : FSM is in LOCKED (packet in progress)
//   o_cur_ch                : granted channel, or the last grant when idle
// -----------------------------------------------------------------------------
module nap_stream_tx_arbiter
    import nap_stream_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = NAP_DATA_WIDTH,
    parameter int ADDR_WIDTH = NAP_ADDR_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [NUM_CH-1:0]            i_valid,
    output logic [NUM_CH-1:0]            o_ready,
    input  logic [NUM_CH-1:0]            i_sop,
    input  logic [NUM_CH-1:0]            i_eop,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_dest,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_sop,
    output logic                         o_eop,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [ADDR_WIDTH-1:0]        o_dest,
    output logic                         o_busy,
    output logic [2:0]                   o_cur_ch
);

    t_arb_state            state_q, state_d;
    logic [2:0]            rr_q, rr_d;
    logic [2:0]            cur_ch_q, cur_ch_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;

    logic [NAP_MAX_CH-1:0] elig;
    logic                  any_elig;
    logic [2:0]            pick;
    logic [2:0]            grant_ch;
    logic                  grant_en;
    logic                  space;
    logic                  accept;

    logic                  g_valid;
    logic                  g_sop;
    logic                  g_eop;
    logic [DATA_WIDTH-1:0] g_data;
    logic [ADDR_WIDTH-1:0] g_dest;

    t_nap_beat             push_beat;
    t_nap_beat             out_beat;

    // Only a valid SOP beat can open a new packet.
    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = i_valid[c] & i_sop[c];
        end
    end

    assign any_elig = |elig;
    assign pick     = rr_pick(elig, rr_q, 32'(NUM_CH));
    assign grant_ch = (state_q == LOCKED) ? cur_ch_q : pick;
    assign grant_en = (state_q == LOCKED) || any_elig;

    // Mux the granted channel's beat.
    always_comb begin
        g_valid = 1'b0;
        g_sop   = 1'b0;
        g_eop   = 1'b0;
        g_data  = '0;
        g_dest  = '0;
        o_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_ch == 3'(c)) begin
                g_valid    = i_valid[c];
                g_sop      = i_sop[c];
                g_eop      = i_eop[c];
                g_data     = i_data[c*DATA_WIDTH +: DATA_WIDTH];
                g_dest     = i_dest[c*ADDR_WIDTH +: ADDR_WIDTH];
                o_ready[c] = grant_en && space;
            end
        end
    end

    assign accept = grant_en && space && g_valid;

    // The opening beat carries the live destination (the value being latched);
    // all later beats of the packet reuse the latched one.
    always_comb begin
        push_beat      = '0;
        push_beat.sop  = g_sop;
        push_beat.eop  = g_eop;
        push_beat.dest = (state_q == IDLE) ? g_dest : dest_q;
        push_beat.data = g_data;
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cur_ch_d = cur_ch_q;
        dest_d   = dest_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_ch_d = grant_ch;
                    dest_d   = g_dest;
                    if (g_eop) rr_d    = rr_next(grant_ch, 32'(NUM_CH));
                    else       state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Mid-packet SOP flags pass through untouched; only EOP matters.
                if (accept && g_eop) begin
                    state_d = IDLE;
                    rr_d    = rr_next(cur_ch_q, 32'(NUM_CH));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            rr_q     <= 3'd0;
            cur_ch_q <= 3'd0;
            dest_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            cur_ch_q <= cur_ch_d;
            dest_q   <= dest_d;
        end
    end

    nap_stream_skid u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (accept),
        .o_ready   (space),
        .i_beat    (push_beat),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_beat    (out_beat)
    );

    assign o_sop    = out_beat.sop;
    assign o_eop    = out_beat.eop;
    assign o_data   = out_beat.data;
    assign o_dest   = out_beat.dest;
    assign o_busy   = (state_q == LOCKED);
    assign o_cur_ch = cur_ch_q;

endmodule

// File: tb/tb_nap_stream_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nap_stream_tx_arbiter
// Directed bench: per-channel source queues feed the DUT, a monitor records
// every NAP-side transfer, and each test compares it with hand-written
// expected beats. Beat tag = {sop, eop, dest[3:0], data[15:0]} with
// data = {channel, packet id, beat index}.
// -----------------------------------------------------------------------------
module tb_nap_stream_tx_arbiter;

    localparam int NUM_CH = 4;
    localparam int DW     = 293;
    localparam int AW     = 4;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_CH-1:0]    i_valid;
    logic [NUM_CH-1:0]    o_ready;
    logic [NUM_CH-1:0]    i_sop;
    logic [NUM_CH-1:0]    i_eop;
    logic [NUM_CH*DW-1:0] i_data;
    logic [NUM_CH*AW-1:0] i_dest;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_sop;
    logic                 o_eop;
    logic [DW-1:0]        o_data;
    logic [AW-1:0]        o_dest;
    logic                 o_busy;
    logic [2:0]           o_cur_ch;

    logic [21:0]       src_q [NUM_CH][$];
    logic [21:0]       exp_q [$];
    logic [21:0]       obs_q [$];
    logic [NUM_CH-1:0] acc_s;
    logic              out_pend;
    logic [21:0]       out_beat;
    int                n_checks;
    int                n_errors;

    nap_stream_tx_arbiter #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_sop     (i_sop),
        .i_eop     (i_eop),
        .i_data    (i_data),
        .i_dest    (i_dest),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sop     (o_sop),
        .o_eop     (o_eop),
        .o_data    (o_data),
        .o_dest    (o_dest),
        .o_busy    (o_busy),
        .o_cur_ch  (o_cur_ch)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] bt(input logic s, input logic e,
                                       input logic [3:0] dest, input logic [15:0] d);
        return {s, e, dest, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Queue a packet on channel ch; beats after the first drive late_dest on i_dest.
    task automatic send_pkt(input int ch, input int pkt, input int nb,
                            input logic [3:0] dest, input logic [3:0] late_dest,
                            input bit add_exp);
        for (int b = 0; b < nb; b++) begin
            logic [15:0] d;
            logic        s;
            logic        e;
            d = {4'(ch), 4'(pkt), 8'(b)};
            s = (b == 0);
            e = (b == nb - 1);
            src_q[ch].push_back(bt(s, e, (b == 0) ? dest : late_dest, d));
            if (add_exp) exp_q.push_back(bt(s, e, dest, d));
        end
    endtask

    task automatic drain(input string tag);
        int          budget;
        logic [21:0] e;
        logic [21:0] o;
        budget = 0;
        while (obs_q.size() < exp_q.size() && budget < 300) begin
            tick();
            budget++;
        end
        repeat (4) tick();
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                chk(tag, 64'(o), 64'(e));
            end
        end
        obs_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    // ---------------- driver ----------------
    initial begin
        logic [21:0] b;
        i_valid = '0;
        i_sop   = '0;
        i_eop   = '0;
        i_data  = '0;
        i_dest  = '0;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (acc_s[c] && src_q[c].size() > 0) b = src_q[c].pop_front();
                end
            end
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (src_q[c].size() > 0) begin
                    b                   = src_q[c][0];
                    i_valid[c]          = 1'b1;
                    i_sop[c]            = b[21];
                    i_eop[c]            = b[20];
                    i_dest[c*AW +: AW]  = b[19:16];
                    i_data[c*DW +: DW]  = {{(DW-16){1'b0}}, b[15:0]};
                end else begin
                    i_valid[c]          = 1'b0;
                    i_sop[c]            = 1'b0;
                    i_eop[c]            = 1'b0;
                    i_dest[c*AW +: AW]  = '0;
                    i_data[c*DW +: DW]  = '0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    // Sampled mid-cycle; a transfer is logged only if reset is still high at
    // the edge that would complete it.
    initial begin
        acc_s    = '0;
        out_pend = 1'b0;
        out_beat = '0;
        forever begin
            @(negedge clk);
            acc_s    = i_valid & o_ready;
            out_pend = o_valid && i_ready;
            out_beat = {o_sop, o_eop, o_dest, o_data[15:0]};
            if (acc_s != '0) begin
                chk("acc_onehot", 64'($countones(acc_s)), 64'd1);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (acc_s[c]) begin
                        if (i_sop[c]) begin
                            chk("busy_at_sop", 64'(o_busy), 64'd0);
                        end else begin
                            chk("busy_in_pkt", 64'(o_busy), 64'd1);
                            chk("cur_ch_in_pkt", 64'(o_cur_ch), 64'(c));
                        end
                    end
                end
            end
            @(posedge clk);
            if (out_pend && rst_n) obs_q.push_back(out_beat);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        i_ready  = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_valid",  64'(o_valid),  64'd0);
        chk("rst_busy",   64'(o_busy),   64'd0);
        chk("rst_ready",  64'(o_ready),  64'd0);
        chk("rst_cur_ch", 64'(o_cur_ch), 64'd0);
        chk("rst_sop",    64'(o_sop),    64'd0);
        chk("rst_eop",    64'(o_eop),    64'd0);
        chk("rst_dest",   64'(o_dest),   64'd0);
        chk("rst_data",   64'(|o_data),  64'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // T1: ch0 3-beat packet, dest 5, latency of one cycle
        send_pkt(0, 1, 3, 4'h5, 4'h5, 1'b1);
        tick();
        chk("t1_ready", 64'(o_ready), 64'(4'b0001));
        chk("t1_lat0",  64'(o_valid), 64'd0);
        tick();
        chk("t1_lat1",  64'(o_valid), 64'd1);
        chk("t1_sop",   64'(o_sop),   64'd1);
        chk("t1_dest",  64'(o_dest),  64'h5);
        chk("t1_busy",  64'(o_busy),  64'd1);
        drain("t1");
        chk("t1_idle",  64'(o_busy),  64'd0);

        // T2: all channels 2-beat packets at once from rr=0
        do_reset();
        for (int c = 0; c < NUM_CH; c++) send_pkt(c, 2, 2, 4'(8 + c), 4'(8 + c), 1'b1);
        drain("t2");

        // T3: ch2 SOP blocked while ch1 is locked; i_dest[1] changes mid-packet
        send_pkt(1, 3, 4, 4'h1, 4'hE, 1'b1);
        tick();
        tick();
        send_pkt(2, 3, 2, 4'h2, 4'h2, 1'b1);
        tick();
        chk("t3_block0", 64'(o_ready),  64'(4'b0010));
        chk("t3_cur1",   64'(o_cur_ch), 64'd1);
        tick();
        chk("t3_block1", 64'(o_ready),  64'(4'b0010));
        tick();
        chk("t3_grant2", 64'(o_ready),  64'(4'b0100));
        chk("t3_idle",   64'(o_busy),   64'd0);
        tick();
        chk("t3_cur2",   64'(o_cur_ch), 64'd2);
        chk("t3_busy2",  64'(o_busy),   64'd1);
        drain("t3");

        // T4: backpressure 1,0,0,1 during a 4-beat stream on ch0
        send_pkt(0, 4, 4, 4'h6, 4'h6, 1'b1);
        tick();
        chk("t4_ready0", 64'(o_ready), 64'(4'b0001));
        tick();
        chk("t4_valid", 64'(o_valid), 64'd1);
        chk("t4_d0",    64'(o_data[15:0]), 64'h0400);
        i_ready = 1'b1;
        tick();
        chk("t4_d1",    64'(o_data[15:0]), 64'h0401);
        i_ready = 1'b0;
        tick();
        chk("t4_full_rdy", 64'(o_ready), 64'd0);
        chk("t4_hold_v",   64'(o_valid), 64'd1);
        chk("t4_hold_d0",  64'(o_data[15:0]), 64'h0401);
        tick();
        chk("t4_full_rdy2", 64'(o_ready), 64'd0);
        chk("t4_hold_d1",   64'(o_data[15:0]), 64'h0401);
        i_ready = 1'b1;
        drain("t4");

        // T5: single-beat packets on ch3 and ch0, rr=1 -> 3,0,3,0
        send_pkt(3, 5, 1, 4'h3, 4'h3, 1'b1);
        send_pkt(0, 5, 1, 4'h0, 4'h0, 1'b1);
        send_pkt(3, 6, 1, 4'h3, 4'h3, 1'b1);
        send_pkt(0, 6, 1, 4'h0, 4'h0, 1'b1);
        drain("t5");
        chk("t5_busy",   64'(o_busy),   64'd0);
        chk("t5_cur_ch", 64'(o_cur_ch), 64'd0);

        // T6: reset on the third beat of a 4-beat ch3 packet
        send_pkt(3, 7, 4, 4'h9, 4'h9, 1'b0);
        exp_q.push_back(bt(1'b1, 1'b0, 4'h9, 16'h3700));
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
        #1;
        chk("t6_valid",  64'(o_valid),  64'd0);
        chk("t6_busy",   64'(o_busy),   64'd0);
        chk("t6_ready",  64'(o_ready),  64'd0);
        chk("t6_cur_ch", 64'(o_cur_ch), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        drain("t6a");
        send_pkt(2, 8, 2, 4'h7, 4'h7, 1'b1);
        tick();
        chk("t6_grant2", 64'(o_ready),  64'(4'b0100));
        tick();
        chk("t6_cur2",   64'(o_cur_ch), 64'd2);
        chk("t6_busy2",  64'(o_busy),   64'd1);
        drain("t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
